// File: rtl/simon_video_pkg.sv
// Shared constants and types for the Simon pad renderer: colour-mask layout,
// default pad geometry and colours, and the stage-1 pipeline record.
package simon_video_pkg;

    localparam int MASK_R = 2;
    localparam int MASK_G = 1;
    localparam int MASK_B = 0;

    localparam logic [3:0] FULL_INTENSITY = 4'hF;
    localparam int         PAD_IDX_W      = 3;

    localparam int DEF_NUM_PADS     = 4;
    localparam int DEF_PAD_X0       = 116;
    localparam int DEF_PAD_PITCH    = 116;
    localparam int DEF_PAD_W        = 59;
    localparam int DEF_PAD_Y0       = 192;
    localparam int DEF_PAD_H        = 97;
    localparam int DEF_DIM_LEVEL    = 2;
    localparam int DEF_FADE_FRAMES  = 4;
    localparam int DEF_BLINK_FRAMES = 30;
    localparam int DEF_V_ACTIVE     = 480;

    // Pads 0..3: blue, green, yellow, red.
    localparam logic [11:0] DEF_PAD_COLORS = 12'b100_110_010_001;

    typedef struct packed {
        logic                 hit;
        logic [PAD_IDX_W-1:0] pad_idx;
        logic                 video_on;
    } stage1_t;

    function automatic logic [10:0] pad_left(input int x0, input int pitch, input int idx);
        return 11'(x0 + idx * pitch);
    endfunction

    function automatic logic [10:0] pad_right(input int x0, input int pitch, input int width,
                                              input int idx);
        return 11'(x0 + idx * pitch + width - 1);
    endfunction

endpackage

// File: rtl/simon_pad_fader.sv
// Per-pad brightness state: snaps to full while lit, then steps down by one
// every FADE_FRAMES frame ticks until it rests at DIM_LEVEL.
module simon_pad_fader
    import simon_video_pkg::*;
#(
    parameter int DIM_LEVEL   = DEF_DIM_LEVEL,
    parameter int FADE_FRAMES = DEF_FADE_FRAMES
) (
    input  logic       clk_d,
    input  logic       rst,
    input  logic       led,
    input  logic       frame_tick,
    output logic [3:0] intensity,
    output logic       fading
);

    localparam int               CNT_W    = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [3:0]       DIM      = 4'(DIM_LEVEL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);

    logic [3:0]       intensity_q, intensity_d;
    logic [CNT_W-1:0] fade_cnt_q, fade_cnt_d;
    logic             fading_q, fading_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        intensity_d = intensity_q;
        fade_cnt_d  = fade_cnt_q;
        if (led) begin
            intensity_d = FULL_INTENSITY;
            fade_cnt_d  = '0;
        end else if (intensity_q > DIM) begin
            if (frame_tick) begin
                if (fade_cnt_q == CNT_LAST) begin
                    intensity_d = intensity_q - 4'd1;
                    fade_cnt_d  = '0;
                end else begin
                    fade_cnt_d = fade_cnt_q + CNT_W'(1);
                end
            end
        end else begin
            fade_cnt_d = '0;
        end
        fading_d = ~led & (intensity_q > DIM);
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            intensity_q <= DIM;
            fade_cnt_q  <= '0;
            fading_q    <= 1'b0;
        end else begin
            intensity_q <= intensity_d;
            fade_cnt_q  <= fade_cnt_d;
            fading_q    <= fading_d;
        end
    end

    assign intensity = intensity_q;
    assign fading    = fading_q;

endmodule

// File: rtl/simon_pad_renderer.sv
// Simon Says pad pixel generator: hit-tests a row of NUM_PADS pads against the
// raster position and emits each pad's masked colour two cycles later.
module simon_pad_renderer
    import simon_video_pkg::*;
#(
    parameter int                      NUM_PADS     = DEF_NUM_PADS,
    parameter int                      PAD_X0       = DEF_PAD_X0,
    parameter int                      PAD_PITCH    = DEF_PAD_PITCH,
    parameter int                      PAD_W        = DEF_PAD_W,
    parameter int                      PAD_Y0       = DEF_PAD_Y0,
    parameter int                      PAD_H        = DEF_PAD_H,
    parameter logic [3*NUM_PADS-1:0]   PAD_COLORS   = (3*NUM_PADS)'(DEF_PAD_COLORS),
    parameter int                      DIM_LEVEL    = DEF_DIM_LEVEL,
    parameter int                      FADE_FRAMES  = DEF_FADE_FRAMES,
    parameter int                      BLINK_FRAMES = DEF_BLINK_FRAMES,
    parameter int                      V_ACTIVE     = DEF_V_ACTIVE
) (
    input  logic                clk_d,
    input  logic                rst,
    input  logic [9:0]          pixel_x,
    input  logic [9:0]          pixel_y,
    input  logic                video_on,
    input  logic [NUM_PADS-1:0] led,
    input  logic                flash_all,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue,
    output logic [NUM_PADS-1:0] fading
);

    localparam int               BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [3:0]       DIM        = 4'(DIM_LEVEL);
    localparam logic [10:0]      Y_LO       = 11'(PAD_Y0);
    localparam logic [10:0]      Y_HI       = 11'(PAD_Y0 + PAD_H - 1);
    localparam logic [9:0]       V_ROW      = 10'(V_ACTIVE);

    logic cond, cond_q, frame_tick;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    stage1_t            s1_q, s1_d;
    logic [3:0]         red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [3:0]         intensity [NUM_PADS];
    logic [3:0]         eff_int   [NUM_PADS];
    logic [2:0]         sel_mask;
    logic [3:0]         sel_int;

    // Edge-detect the frame condition so a held pixel position ticks once.
    assign cond       = (pixel_x == 10'd0) && (pixel_y == V_ROW);
    assign frame_tick = cond & ~cond_q;

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        simon_pad_fader #(
            .DIM_LEVEL   (DIM_LEVEL),
            .FADE_FRAMES (FADE_FRAMES)
        ) u_fader (
            .clk_d      (clk_d),
            .rst        (rst),
            .led        (led[g]),
            .frame_tick (frame_tick),
            .intensity  (intensity[g]),
            .fading     (fading[g])
        );
    end

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!flash_all) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Descending scan: the lowest overlapping pad index is written last and wins.
    always_comb begin
        logic [10:0] x11, y11;
        logic        y_in;
        x11  = {1'b0, pixel_x};
        y11  = {1'b0, pixel_y};
        y_in = (y11 >= Y_LO) && (y11 <= Y_HI);
        s1_d = '{hit: 1'b0, pad_idx: '0, video_on: video_on};
        for (int i = NUM_PADS - 1; i >= 0; i--) begin
            if (y_in && (x11 >= pad_left(PAD_X0, PAD_PITCH, i))
                     && (x11 <= pad_right(PAD_X0, PAD_PITCH, PAD_W, i))) begin
                s1_d.hit     = 1'b1;
                s1_d.pad_idx = PAD_IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PADS; i++) begin
            eff_int[i] = flash_all ? (blink_phase_q ? FULL_INTENSITY : DIM) : intensity[i];
        end
    end

    always_comb begin
        sel_mask = 3'b000;
        sel_int  = 4'h0;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (s1_q.pad_idx == PAD_IDX_W'(i)) begin
                sel_mask = PAD_COLORS[3*i +: 3];
                sel_int  = eff_int[i];
            end
        end
        red_d   = 4'h0;
        green_d = 4'h0;
        blue_d  = 4'h0;
        if (s1_q.video_on && s1_q.hit) begin
            red_d   = sel_mask[MASK_R] ? sel_int : 4'h0;
            green_d = sel_mask[MASK_G] ? sel_int : 4'h0;
            blue_d  = sel_mask[MASK_B] ? sel_int : 4'h0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_d) begin
        if (rst) begin
            cond_q        <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            s1_q          <= '0;
            red_q         <= 4'h0;
            green_q       <= 4'h0;
            blue_q        <= 4'h0;
        end else begin
            cond_q        <= cond;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            s1_q          <= s1_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;

endmodule

// File: tb/tb_simon_pad_renderer.sv
// Directed bench for simon_pad_renderer: idle colour/geometry table, fade,
// re-light, flash_all blinking, held-pixel frame ticks and overlap/reset.
module tb_simon_pad_renderer;

    logic       clk_d = 1'b0;
    logic       rst;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on;
    logic [3:0] led;
    logic [5:0] led6;
    logic       flash_all;
    logic [3:0] red, green, blue, fading;
    logic [3:0] red6, green6, blue6;
    logic [5:0] fading6;

    always #5 clk_d = ~clk_d;

    simon_pad_renderer dut (
        .clk_d(clk_d), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .led(led), .flash_all(flash_all),
        .red(red), .green(green), .blue(blue), .fading(fading)
    );

    simon_pad_renderer #(
        .NUM_PADS(6), .PAD_X0(50), .PAD_PITCH(90), .PAD_W(100),
        .PAD_COLORS(18'b000_000_100_110_010_001)
    ) dut6 (
        .clk_d(clk_d), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .led(led6), .flash_all(flash_all),
        .red(red6), .green(green6), .blue(blue6), .fading(fading6)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        vid;
        logic [11:0] rgb;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_d);
    endtask

    task automatic show(input int x, input int y);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = 1'b1;
        step(2);
    endtask

    // One frame tick; hold > 1 models a clock faster than the pixel rate.
    task automatic ticks(input int n, input int hold);
        for (int k = 0; k < n; k++) begin
            pixel_x  = 10'd0;
            pixel_y  = 10'd480;
            video_on = 1'b0;
            step(hold);
            pixel_x = 10'd1;
            step(1);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        led       = '0;
        led6      = '0;
        flash_all = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    function automatic logic [11:0] rgb();
        return {red, green, blue};
    endfunction

    function automatic logic [11:0] rgb6();
        return {red6, green6, blue6};
    endfunction

    initial begin
        rst = 1'b1; led = '0; led6 = '0; flash_all = 1'b0;
        pixel_x = 10'd150; pixel_y = 10'd240; video_on = 1'b1;
        step(3);
        check("reset_rgb", 32'(rgb()), 32'h000);
        check("reset_fading", 32'(fading), 32'h0);
        rst = 1'b0;
        step(1);

        // Idle geometry and colours at DIM_LEVEL=2.
        vecs.push_back('{10'd150, 10'd240, 1'b1, 12'h002});
        vecs.push_back('{10'd200, 10'd240, 1'b1, 12'h000});
        vecs.push_back('{10'd380, 10'd200, 1'b1, 12'h220});
        vecs.push_back('{10'd500, 10'd250, 1'b1, 12'h200});
        vecs.push_back('{10'd250, 10'd240, 1'b1, 12'h020});
        vecs.push_back('{10'd116, 10'd240, 1'b1, 12'h002});
        vecs.push_back('{10'd174, 10'd240, 1'b1, 12'h002});
        vecs.push_back('{10'd115, 10'd240, 1'b1, 12'h000});
        vecs.push_back('{10'd175, 10'd240, 1'b1, 12'h000});
        vecs.push_back('{10'd150, 10'd192, 1'b1, 12'h002});
        vecs.push_back('{10'd150, 10'd288, 1'b1, 12'h002});
        vecs.push_back('{10'd150, 10'd191, 1'b1, 12'h000});
        vecs.push_back('{10'd150, 10'd289, 1'b1, 12'h000});
        vecs.push_back('{10'd150, 10'd240, 1'b0, 12'h000});
        vecs.push_back('{10'd522, 10'd250, 1'b1, 12'h200});
        vecs.push_back('{10'd523, 10'd250, 1'b1, 12'h000});
        foreach (vecs[i]) begin
            pixel_x  = vecs[i].x;
            pixel_y  = vecs[i].y;
            video_on = vecs[i].vid;
            step(2);
            check($sformatf("idle_vec%0d", i), 32'(rgb()), 32'(vecs[i].rgb));
        end

        // Pad 3 lit, released, fading with 4x-held frame positions first.
        led[3] = 1'b1;
        show(500, 250);
        check("lit_red", 32'(rgb()), 32'hF00);
        check("lit_not_fading", 32'(fading), 32'h0);
        led[3] = 1'b0;
        step(1);
        check("release_fading", 32'(fading), 32'h8);
        ticks(3, 4);
        show(500, 250);
        check("fade_3ticks", 32'(rgb()), 32'hF00);
        ticks(1, 4);
        show(500, 250);
        check("fade_4ticks", 32'(rgb()), 32'hE00);
        ticks(47, 1);
        show(500, 250);
        check("fade_51ticks", 32'(rgb()), 32'h300);
        check("fade_51_fading", 32'(fading), 32'h8);
        ticks(1, 1);
        show(500, 250);
        check("fade_52ticks", 32'(rgb()), 32'h200);
        check("fade_52_fading", 32'(fading), 32'h0);
        ticks(8, 1);
        show(500, 250);
        check("fade_floor", 32'(rgb()), 32'h200);

        // Re-light at intensity 9 on the same cycle as a frame tick.
        do_reset();
        led[3] = 1'b1;
        step(1);
        led[3] = 1'b0;
        ticks(24, 1);
        show(500, 250);
        check("mid_fade_9", 32'(rgb()), 32'h900);
        ticks(2, 1);
        pixel_x = 10'd0; pixel_y = 10'd480; video_on = 1'b0; led[3] = 1'b1;
        step(1);
        led[3] = 1'b0; pixel_x = 10'd1;
        step(1);
        show(500, 250);
        check("relight_full", 32'(rgb()), 32'hF00);
        ticks(3, 1);
        show(500, 250);
        check("relight_cnt_cleared", 32'(rgb()), 32'hF00);
        ticks(1, 1);
        show(500, 250);
        check("relight_first_step", 32'(rgb()), 32'hE00);

        // flash_all blinking over a faded pad 0.
        do_reset();
        led[0] = 1'b1;
        step(1);
        led[0] = 1'b0;
        flash_all = 1'b1;
        show(150, 240);
        check("flash_on_pad0", 32'(rgb()), 32'h00F);
        show(250, 240);
        check("flash_on_pad1", 32'(rgb()), 32'h0F0);
        ticks(29, 1);
        show(250, 240);
        check("flash_29", 32'(rgb()), 32'h0F0);
        ticks(1, 1);
        show(250, 240);
        check("flash_30_dim", 32'(rgb()), 32'h020);
        show(150, 240);
        check("flash_30_pad0_dim", 32'(rgb()), 32'h002);
        ticks(29, 1);
        show(380, 200);
        check("flash_59_dim", 32'(rgb()), 32'h220);
        ticks(1, 1);
        show(380, 200);
        check("flash_60_on", 32'(rgb()), 32'hFF0);

        // Drop flash_all after 10 frames: pad 0 shows its faded value.
        do_reset();
        led[0] = 1'b1;
        step(1);
        led[0] = 1'b0;
        flash_all = 1'b1;
        ticks(10, 1);
        show(150, 240);
        check("flash10_on", 32'(rgb()), 32'h00F);
        flash_all = 1'b0;
        show(150, 240);
        check("flash_release_faded", 32'(rgb()), 32'h00D);
        flash_all = 1'b1;
        ticks(29, 1);
        show(250, 240);
        check("reflash_cnt_restart", 32'(rgb()), 32'h0F0);
        ticks(1, 1);
        show(250, 240);
        check("reflash_dim", 32'(rgb()), 32'h020);
        flash_all = 1'b0;

        // Overlapping six-pad variant and mid-line reset.
        do_reset();
        show(145, 240);
        check("overlap_pad0_wins", 32'(rgb6()), 32'h002);
        show(150, 240);
        check("overlap_pad1_only", 32'(rgb6()), 32'h020);
        show(145, 240);
        rst = 1'b1;
        step(1);
        check("midline_rst_rgb6", 32'(rgb6()), 32'h000);
        check("midline_rst_rgb", 32'(rgb()), 32'h000);
        rst = 1'b0;
        step(1);
        check("post_rst_1cyc", 32'(rgb6()), 32'h000);
        step(1);
        check("post_rst_2cyc", 32'(rgb6()), 32'h002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
